// File: rtl/result_storer_if.sv
// Result-sample input stream and DMA write channel used by result_storer.
// The slave modport is the storer's view; the master modport is the environment's view.
interface result_storer_if #(
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned BITS_TRANS   = 18,
    parameter int unsigned AXI_WIDTH_AD = 32,
    parameter int unsigned AXI_WIDTH_DA = 32
);
    logic [DATA_BITS-1:0]    data_i;
    logic                    data_vld_i;
    logic                    data_rdy_o;
    logic                    start_dma;
    logic [BITS_TRANS-1:0]   dma_num_trans;
    logic [AXI_WIDTH_AD-1:0] dma_start_addr;
    logic [AXI_WIDTH_DA-1:0] dma_dout;
    logic                    dma_dout_vld;
    logic                    dma_dout_rdy;
    logic                    dma_done;

    modport slave (
        input  data_i, data_vld_i, dma_dout_rdy, dma_done,
        output data_rdy_o, start_dma, dma_num_trans, dma_start_addr, dma_dout, dma_dout_vld
    );

    modport master (
        output data_i, data_vld_i, dma_dout_rdy, dma_done,
        input  data_rdy_o, start_dma, dma_num_trans, dma_start_addr, dma_dout, dma_dout_vld
    );
endinterface

// File: rtl/result_storer.sv
// Collects one layer of 16-bit results packed two per word, then streams the buffer to the DMA write channel.
// Optional STORER_RELU_EN: clamp negative samples to zero before packing.
module result_storer #(
    parameter int unsigned DATA_BITS    = 16,
    parameter int unsigned BITS_TRANS   = 18,
    parameter int unsigned AXI_WIDTH_AD = 32,
    parameter int unsigned AXI_WIDTH_DA = 32,
    parameter int unsigned BUF_DEPTH    = 256,
    parameter int unsigned BUF_ADDR     = $clog2(BUF_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ap_start,
    input  logic [BITS_TRANS-1:0]   num_items,
    input  logic [AXI_WIDTH_AD-1:0] store_start_addr,
    output logic                    busy,
    output logic                    store_done,
    result_storer_if.slave          bus
);
    localparam logic [BITS_TRANS-1:0] MAX_ITEMS = BITS_TRANS'(2 * BUF_DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COLLECT   = 3'd1;
    localparam logic [2:0] REQ_DMA   = 3'd2;
    localparam logic [2:0] STREAM    = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    logic [2:0]              state, state_nxt;
    logic [BITS_TRANS-1:0]   n_items;
    logic [BITS_TRANS-1:0]   cnt;
    logic [BITS_TRANS-1:0]   rd_ptr;
    logic [BITS_TRANS-1:0]   out_cnt;
    logic [DATA_BITS-1:0]    hi_half;
    logic [AXI_WIDTH_DA-1:0] mem [BUF_DEPTH];
    logic [AXI_WIDTH_DA-1:0] mem_q;
    logic                    rd_pend;
    logic [AXI_WIDTH_DA-1:0] skid;
    logic                    skid_vld;
    logic                    done_seen;

    logic [DATA_BITS-1:0]    sample_c;
    logic [BITS_TRANS-1:0]   n_sat_c;
    logic                    in_xfer_c;
    logic                    out_xfer_c;
    logic                    wr_en_c;
    logic [AXI_WIDTH_DA-1:0] wr_data_c;
    logic                    rd_en_c;
    logic [1:0]              occ_c;
    logic                    done_pulse_c;
    logic                    launch_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and datapath strobes
    always_comb begin
        state_nxt    = state;
        done_pulse_c = 1'b0;
        launch_c     = 1'b0;
`ifdef STORER_RELU_EN
        sample_c     = bus.data_i[DATA_BITS-1] ? '0 : bus.data_i;
`else
        sample_c     = bus.data_i;
`endif
        n_sat_c      = (num_items > MAX_ITEMS) ? MAX_ITEMS : num_items;
        in_xfer_c    = bus.data_vld_i & bus.data_rdy_o;
        out_xfer_c   = bus.dma_dout_vld & bus.dma_dout_rdy;
        wr_en_c      = in_xfer_c & (cnt[0] | (cnt == n_items - BITS_TRANS'(1)));
        wr_data_c    = cnt[0] ? {hi_half, sample_c} : {sample_c, DATA_BITS'(0)};
        // Words held or in flight never exceed the two output slots
        occ_c        = 2'(bus.dma_dout_vld) + 2'(skid_vld) + 2'(rd_pend);
        rd_en_c      = ((state == REQ_DMA) || (state == STREAM)) &&
                       (rd_ptr < bus.dma_num_trans) &&
                       ((occ_c - 2'(out_xfer_c)) < 2'd2);

        case (state)
            IDLE: begin
                if (ap_start) begin
                    launch_c = 1'b1;
                    if (num_items == '0) done_pulse_c = 1'b1;
                    else                 state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (in_xfer_c && (cnt == n_items - BITS_TRANS'(1))) state_nxt = REQ_DMA;
            end
            REQ_DMA: state_nxt = STREAM;
            STREAM: begin
                if (out_xfer_c && (out_cnt == bus.dma_num_trans - BITS_TRANS'(1))) begin
                    if (done_seen || bus.dma_done) begin
                        state_nxt    = IDLE;
                        done_pulse_c = 1'b1;
                    end else begin
                        state_nxt = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.dma_done) begin
                    state_nxt    = IDLE;
                    done_pulse_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Packed-word buffer with one-cycle read latency
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[cnt[BUF_ADDR:1]] <= wr_data_c;
        if (rd_en_c) mem_q <= mem[rd_ptr[BUF_ADDR-1:0]];
    end

    // Control registers, counters and the output/skid stage
    always_ff @(posedge clk) begin
        if (rst) begin
            busy               <= 1'b0;
            store_done         <= 1'b0;
            bus.data_rdy_o     <= 1'b0;
            bus.start_dma      <= 1'b0;
            bus.dma_num_trans  <= '0;
            bus.dma_start_addr <= '0;
            bus.dma_dout       <= '0;
            bus.dma_dout_vld   <= 1'b0;
            n_items            <= '0;
            cnt                <= '0;
            rd_ptr             <= '0;
            out_cnt            <= '0;
            hi_half            <= '0;
            rd_pend            <= 1'b0;
            skid               <= '0;
            skid_vld           <= 1'b0;
            done_seen          <= 1'b0;
        end else begin
            busy           <= (state_nxt != IDLE);
            store_done     <= done_pulse_c;
            bus.data_rdy_o <= (state_nxt == COLLECT);
            bus.start_dma  <= (state_nxt == REQ_DMA);
            rd_pend        <= rd_en_c;

            if (launch_c) begin
                n_items            <= n_sat_c;
                bus.dma_num_trans  <= (n_sat_c + BITS_TRANS'(1)) >> 1;
                bus.dma_start_addr <= store_start_addr;
                cnt                <= '0;
                rd_ptr             <= '0;
                out_cnt            <= '0;
                done_seen          <= 1'b0;
            end

            if (in_xfer_c) begin
                cnt <= cnt + BITS_TRANS'(1);
                if (!cnt[0]) hi_half <= sample_c;
            end

            if (rd_en_c)    rd_ptr  <= rd_ptr + BITS_TRANS'(1);
            if (out_xfer_c) out_cnt <= out_cnt + BITS_TRANS'(1);
            if ((state == STREAM) && bus.dma_done) done_seen <= 1'b1;

            // Skid holds the younger word while the presented one is stalled
            if (!bus.dma_dout_vld || out_xfer_c) begin
                if (skid_vld) begin
                    bus.dma_dout     <= skid;
                    bus.dma_dout_vld <= 1'b1;
                    skid_vld         <= rd_pend;
                    if (rd_pend) skid <= mem_q;
                end else if (rd_pend) begin
                    bus.dma_dout     <= mem_q;
                    bus.dma_dout_vld <= 1'b1;
                end else begin
                    bus.dma_dout_vld <= 1'b0;
                end
            end else if (rd_pend) begin
                skid     <= mem_q;
                skid_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_result_storer.sv
// Scoreboard bench for result_storer: stimulus pushes expected DMA requests, words and done pulses; a monitor pops and compares.
module tb_result_storer;
    localparam int unsigned DATA_BITS    = 16;
    localparam int unsigned BITS_TRANS   = 18;
    localparam int unsigned AXI_WIDTH_AD = 32;
    localparam int unsigned AXI_WIDTH_DA = 32;
    localparam int unsigned BUF_DEPTH    = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        ap_start;
    logic [17:0] num_items;
    logic [31:0] store_start_addr;
    logic        busy;
    logic        store_done;

    result_storer_if #(
        .DATA_BITS(DATA_BITS), .BITS_TRANS(BITS_TRANS),
        .AXI_WIDTH_AD(AXI_WIDTH_AD), .AXI_WIDTH_DA(AXI_WIDTH_DA)
    ) bus ();

    result_storer #(
        .DATA_BITS(DATA_BITS), .BITS_TRANS(BITS_TRANS), .AXI_WIDTH_AD(AXI_WIDTH_AD),
        .AXI_WIDTH_DA(AXI_WIDTH_DA), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ap_start(ap_start), .num_items(num_items),
        .store_start_addr(store_start_addr), .busy(busy), .store_done(store_done), .bus(bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_words[$];
    logic [49:0] exp_req[$];
    int          pending_done = 0;
    int          done_cnt = 0;
    logic [15:0] stim[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef STORER_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    // Monitor: pops expectations whenever the DUT presents a request, a word or a done pulse
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dout = '0;
    int          since_start = -1;
    logic        got_vld = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            since_start = -1;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", 64'(bus.dma_dout_vld), 64'd1);
                chk("hold_data", 64'(bus.dma_dout), 64'(prev_dout));
            end
            if (since_start >= 0) begin
                since_start++;
                if (bus.dma_dout_vld) got_vld = 1'b1;
                if (since_start == 2) begin
                    chk("first_vld_latency", 64'(got_vld), 64'd1);
                    since_start = -1;
                end
            end
            if (bus.start_dma) begin
                if (exp_req.size() == 0) chk("start_dma_unexpected", 64'(bus.start_dma), 64'd0);
                else chk("dma_req", 64'({bus.dma_num_trans, bus.dma_start_addr}), 64'(exp_req.pop_front()));
                since_start = 0;
                got_vld     = 1'b0;
            end
            if (bus.dma_dout_vld && bus.dma_dout_rdy) begin
                if (exp_words.size() == 0) chk("dout_unexpected", 64'(bus.dma_dout_vld), 64'd0);
                else chk("dout", 64'(bus.dma_dout), 64'(exp_words.pop_front()));
            end
            if (store_done) begin
                if (pending_done == 0) chk("store_done_unexpected", 64'(store_done), 64'd0);
                else begin
                    pending_done--;
                    done_cnt++;
                    chk("store_done_after_data", 64'(exp_words.size()), 64'd0);
                end
            end
            prev_stall = bus.dma_dout_vld & ~bus.dma_dout_rdy;
            prev_dout  = bus.dma_dout;
        end
    end

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(store_done), 64'd0);
        chk({tag, "_rdy"}, 64'(bus.data_rdy_o), 64'd0);
        chk({tag, "_start"}, 64'(bus.start_dma), 64'd0);
        chk({tag, "_vld"}, 64'(bus.dma_dout_vld), 64'd0);
        chk({tag, "_req"}, 64'({bus.dma_num_trans, bus.dma_start_addr}), 64'd0);
        chk({tag, "_dout"}, 64'(bus.dma_dout), 64'd0);
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random; abort_after>0 resets after that many words
    task automatic run_layer(input int n_req, input logic [31:0] addr, input int rdy_mode,
                             input bit early, input int abort_after);
        int n, words, got, extra, cyc, acc, dd, gaps, done_before;
        bit done_sent, finish_next;
        logic [15:0] a, b;
        n     = (n_req > 2 * BUF_DEPTH) ? 2 * BUF_DEPTH : n_req;
        words = (n + 1) / 2;
        for (int w = 0; w < words; w++) begin
            a = relu(stim[2 * w]);
            b = (2 * w + 1 < n) ? relu(stim[2 * w + 1]) : 16'h0000;
            exp_words.push_back({a, b});
        end
        if (n > 0) exp_req.push_back({18'(words), addr});
        pending_done++;
        done_before = done_cnt;

        num_items = 18'(n_req); store_start_addr = addr; ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;

        got = 0; cyc = 0;
        while (got < n && cyc < 5000) begin
            bus.data_i     = stim[got];
            bus.data_vld_i = ($urandom_range(3) != 0);
            ap_start       = (cyc == 2);
            num_items      = 18'd5;
            if (bus.data_vld_i && bus.data_rdy_o) got++;
            @(posedge clk); #1;
            cyc++;
        end
        ap_start = 1'b0;
        chk("samples_accepted", 64'(got), 64'(n));

        extra = 0;
        for (int i = 0; i < 3; i++) begin
            bus.data_i     = (got + i < stim.size()) ? stim[got + i] : 16'h5A5A;
            bus.data_vld_i = 1'b1;
            if (bus.data_rdy_o) extra++;
            if (n == 0) chk("busy_zero_items", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end
        bus.data_vld_i = 1'b0;
        chk("excess_accepted", 64'(extra), 64'd0);

        acc = 0; cyc = 0; dd = 0; gaps = 0; done_sent = 1'b0;
        while (done_cnt == done_before && cyc < 5000) begin
            if (abort_after > 0 && acc == abort_after) begin
                rst = 1'b1; bus.dma_dout_rdy = 1'b0; bus.dma_done = 1'b0;
                exp_words.delete();
                pending_done--;
                @(posedge clk); #1;
                check_idle_outputs("abort");
                rst = 1'b0;
                return;
            end
            case (rdy_mode)
                0:       bus.dma_dout_rdy = 1'b1;
                1:       bus.dma_dout_rdy = (cyc % 3 == 0);
                default: bus.dma_dout_rdy = 1'($urandom_range(1));
            endcase
            bus.dma_done = 1'b0;
            finish_next  = 1'b0;
            if (!done_sent) begin
                if (early && bus.dma_dout_vld) begin
                    bus.dma_done = 1'b1; bus.dma_dout_rdy = 1'b0; done_sent = 1'b1;
                end else if (!early && acc == words) begin
                    if (dd == 2) begin
                        bus.dma_done = 1'b1; done_sent = 1'b1; finish_next = 1'b1;
                    end
                    dd++;
                end
            end
            if (acc > 0 && acc < words && !bus.dma_dout_vld) gaps++;
            if (bus.dma_dout_vld && bus.dma_dout_rdy) begin
                acc++;
                if (early && done_sent && acc == words) finish_next = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (finish_next) chk("done_latency", 64'(store_done), 64'd1);
        end
        bus.dma_done = 1'b0; bus.dma_dout_rdy = 1'b0;
        chk("store_done_seen", 64'(done_cnt - done_before), 64'd1);
        chk("words_accepted", 64'(acc), 64'(words));
        if (rdy_mode == 0) chk("throughput_gaps", 64'(gaps), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ap_start = 1'b0; num_items = '0; store_start_addr = '0;
        bus.data_i = '0; bus.data_vld_i = 1'b0; bus.dma_dout_rdy = 1'b0; bus.dma_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        stim.delete();
        stim.push_back(16'h0001); stim.push_back(16'h0002);
        stim.push_back(16'h0003); stim.push_back(16'h0004);
        run_layer(4, 32'h1000_0000, 0, 1'b0, 0);

        stim.delete();
        stim.push_back(16'hAAAA); stim.push_back(16'hBBBB); stim.push_back(16'hCCCC);
        run_layer(3, 32'h2000_0040, 0, 1'b0, 0);

        fill_random(8);
        run_layer(8, 32'h3000_0100, 1, 1'b0, 0);

        stim.delete();
        run_layer(0, 32'h4000_0000, 0, 1'b0, 0);

        fill_random(4);
        run_layer(4, 32'h5000_0000, 0, 1'b0, 2);
        fill_random(2);
        run_layer(2, 32'h5000_0200, 0, 1'b0, 0);

        stim.delete();
        stim.push_back(16'h8001); stim.push_back(16'h7FFF);
        run_layer(2, 32'h6000_0000, 0, 1'b0, 0);

        fill_random(5);
        run_layer(5, 32'h7000_0000, 2, 1'b1, 0);

        fill_random(600);
        run_layer(600, 32'h8000_0000, 0, 1'b0, 0);

        for (int t = 0; t < 10; t++) begin
            int n;
            n = $urandom_range(40, 1);
            fill_random(n);
            run_layer(n, $urandom & 32'hFFFF_FFFC, $urandom_range(2), 1'($urandom_range(1)), 0);
        end

        chk("queues_drained", 64'(exp_words.size() + exp_req.size() + pending_done), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
